// File: rtl/flatten_serializer_if.sv
// Frame-in / element-out bundle between the flattened feature source, the serializer and the FC layer.
interface flatten_serializer_if #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned LENGTH   = 72
);
  logic [BITWIDTH*LENGTH-1:0] frame_in;
  logic                       frame_in_valid;
  logic                       frame_in_ready;
  logic [BITWIDTH-1:0]        data_out;
  logic                       data_out_valid;
  logic                       frame_start;
  logic                       frame_last;
  logic                       busy;
  logic                       overflow;

  modport master (
    output frame_in, frame_in_valid,
    input  frame_in_ready, data_out, data_out_valid, frame_start, frame_last, busy, overflow
  );

  modport slave (
    input  frame_in, frame_in_valid,
    output frame_in_ready, data_out, data_out_valid, frame_start, frame_last, busy, overflow
  );
endinterface

// File: rtl/flatten_serializer.sv
// Ping-pong buffered serializer: captures whole flattened frames into two slots and
// streams them element 0 first, one element per enabled cycle, with no bubble between frames.
module flatten_serializer #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned LENGTH   = 72
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clken,
  flatten_serializer_if.slave  bus
);
  localparam int unsigned FW = BITWIDTH * LENGTH;
  localparam int unsigned IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef enum logic {IDLE, STREAM} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [1:0]          full_q, full_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [BITWIDTH-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                start_q, start_d;
  logic                last_q, last_d;
  logic [FW-1:0]       slot_q [2];

  logic                ready;
  logic                capture;
  logic                free_slot;
  logic [IW-1:0]       sel_idx;
  logic [FW-1:0]       cur_frame;
  logic [BITWIDTH-1:0] elem;

  assign ready     = ~(full_q[0] & full_q[1]);
  assign capture   = clken & bus.frame_in_valid & ready;
  assign cur_frame = slot_q[rd_ptr_q];
  assign elem      = cur_frame[32'(sel_idx) * BITWIDTH +: BITWIDTH];

  // Next-state and output-register logic; everything holds while clken is low.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    full_d    = full_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    start_d   = start_q;
    last_d    = last_q;
    free_slot = 1'b0;
    sel_idx   = idx_q;

    if (clken) begin
      data_d  = '0;
      valid_d = 1'b0;
      start_d = 1'b0;
      last_d  = 1'b0;

      unique case (state_q)
        IDLE: begin
          if (full_q[rd_ptr_q]) begin
            sel_idx = '0;
            data_d  = elem;
            valid_d = 1'b1;
            start_d = 1'b1;
            if (LENGTH > 1) begin
              idx_d   = IW'(1);
              state_d = STREAM;
            end else begin
              last_d    = 1'b1;
              free_slot = 1'b1;
            end
          end
        end
        STREAM: begin
          data_d  = elem;
          valid_d = 1'b1;
          start_d = (idx_q == '0);
          idx_d   = idx_q + IW'(1);
          // On the last element, chain straight into a waiting frame by wrapping idx to 0.
          if (idx_q == IW'(LENGTH - 1)) begin
            last_d    = 1'b1;
            free_slot = 1'b1;
            idx_d     = '0;
            state_d   = full_q[~rd_ptr_q] ? STREAM : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (free_slot) begin
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
      end
      if (capture) begin
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      start_q  <= start_d;
      last_q   <= last_d;
    end
  end

  // Slot payloads need no reset; the full flags alone decide what is live.
  always_ff @(posedge clk) begin
    if (capture) slot_q[wr_ptr_q] <= bus.frame_in;
  end

  assign bus.frame_in_ready = ready;
  assign bus.overflow       = ~rst & clken & bus.frame_in_valid & ~ready;
  assign bus.data_out       = data_q;
  assign bus.data_out_valid = valid_q;
  assign bus.frame_start    = start_q;
  assign bus.frame_last     = last_q;
  assign bus.busy           = (state_q == STREAM) | full_q[0] | full_q[1];
endmodule

// File: tb/tb_flatten_serializer.sv
// Bench for flatten_serializer: frame-queue reference model with directed and random stimulus,
// plus a LENGTH=1 instance checked against the previous cycle's input.
module tb_flatten_serializer;
  localparam int unsigned BW  = 8;
  localparam int unsigned LEN = 72;
  localparam int unsigned FW  = BW * LEN;

  logic clk = 1'b0;
  logic rst;
  logic clken;
  logic clken1;

  always #5 clk = ~clk;

  flatten_serializer_if #(.BITWIDTH(BW), .LENGTH(LEN)) bus ();
  flatten_serializer_if #(.BITWIDTH(BW), .LENGTH(1))   bus1 ();

  flatten_serializer #(.BITWIDTH(BW), .LENGTH(LEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .bus   (bus)
  );

  flatten_serializer #(.BITWIDTH(BW), .LENGTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .clken (clken1),
    .bus   (bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frames waiting or streaming, and the position inside the head frame.
  logic [FW-1:0] mq[$];
  int            pos = 0;
  logic [BW-1:0] e_data;
  logic          e_valid, e_start, e_last;

  int n_seen, n_start_seen, n_ovf_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] elem_of(input logic [FW-1:0] f, input int k);
    return f[k*BW +: BW];
  endfunction

  function automatic logic [FW-1:0] ramp_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < int'(LEN); k++) f[k*BW +: BW] = BW'(k + 1);
    return f;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < int'(LEN); k++) f[k*BW +: BW] = BW'($urandom);
    return f;
  endfunction

  // One clock: drive inputs, check the combinational outputs, advance model and DUT, check registers.
  task automatic step(input logic r, input logic en, input logic v, input logic [FW-1:0] f);
    int pre;
    rst                = r;
    clken              = en;
    bus.frame_in_valid = v;
    bus.frame_in       = f;
    #1;
    pre = mq.size();
    check("ready", 64'(bus.frame_in_ready), 64'(pre < 2));
    check("overflow", 64'(bus.overflow), 64'(!r && en && v && pre == 2));
    if (bus.overflow) n_ovf_seen++;
    @(posedge clk);
    if (r) begin
      mq.delete();
      pos     = 0;
      e_data  = '0;
      e_valid = 1'b0;
      e_start = 1'b0;
      e_last  = 1'b0;
    end else if (en) begin
      if (pre > 0) begin
        e_data  = elem_of(mq[0], pos);
        e_valid = 1'b1;
        e_start = (pos == 0);
        e_last  = (pos == int'(LEN) - 1);
        pos++;
        if (pos == int'(LEN)) begin
          void'(mq.pop_front());
          pos = 0;
        end
      end else begin
        e_data  = '0;
        e_valid = 1'b0;
        e_start = 1'b0;
        e_last  = 1'b0;
      end
      if (v && pre < 2) mq.push_back(f);
    end
    #1;
    check("data_out", 64'(bus.data_out), 64'(e_data));
    check("data_out_valid", 64'(bus.data_out_valid), 64'(e_valid));
    check("frame_start", 64'(bus.frame_start), 64'(e_start));
    check("frame_last", 64'(bus.frame_last), 64'(e_last));
    check("busy", 64'(bus.busy), 64'(mq.size() > 0));
    if (en && !r && bus.data_out_valid) n_seen++;
    if (en && !r && bus.frame_start) n_start_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic clear_counts();
    n_seen       = 0;
    n_start_seen = 0;
    n_ovf_seen   = 0;
  endtask

  logic [FW-1:0] fa, fb;
  logic [BW-1:0] prev1, cur1;

  initial begin
    clken1              = 1'b1;
    bus1.frame_in_valid = 1'b0;
    bus1.frame_in       = '0;
    e_data = '0; e_valid = 1'b0; e_start = 1'b0; e_last = 1'b0;
    clear_counts();

    // Reset state
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("rst_ready", 64'(bus.frame_in_ready), 64'(1));
    check("rst_valid", 64'(bus.data_out_valid), 64'(0));

    // Single ramp frame
    clear_counts();
    step(1'b0, 1'b1, 1'b1, ramp_frame());
    idle(75);
    check("ramp_count", 64'(n_seen), 64'(72));
    check("ramp_starts", 64'(n_start_seen), 64'(1));

    // Back-to-back: A all 0x11, B element k = -k loaded while A streams
    clear_counts();
    for (int k = 0; k < int'(LEN); k++) begin
      fa[k*BW +: BW] = 8'h11;
      fb[k*BW +: BW] = BW'(0 - k);
    end
    step(1'b0, 1'b1, 1'b1, fa);
    idle(10);
    step(1'b0, 1'b1, 1'b1, fb);
    idle(150);
    check("b2b_count", 64'(n_seen), 64'(144));
    check("b2b_starts", 64'(n_start_seen), 64'(2));

    // Overflow: three frames on consecutive cycles
    clear_counts();
    step(1'b0, 1'b1, 1'b1, rand_frame());
    step(1'b0, 1'b1, 1'b1, rand_frame());
    step(1'b0, 1'b1, 1'b1, rand_frame());
    idle(150);
    check("ovf_pulses", 64'(n_ovf_seen), 64'(1));
    check("ovf_count", 64'(n_seen), 64'(144));

    // clken toggling during a ramp frame, with frames offered on disabled cycles
    clear_counts();
    step(1'b0, 1'b1, 1'b1, ramp_frame());
    step(1'b0, 1'b1, 1'b1, rand_frame());
    for (int i = 0; i < 320; i++) step(1'b0, 1'(i % 2), 1'(i % 2 == 0), rand_frame());
    idle(80);
    check("clken_ovf", 64'(n_ovf_seen), 64'(0));

    // Reset mid-frame with element 30 on data_out and the other slot full
    clear_counts();
    step(1'b0, 1'b1, 1'b1, ramp_frame());
    step(1'b0, 1'b1, 1'b1, rand_frame());
    for (int i = 0; i < 100 && pos != 31; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("mid_elem30", 64'(bus.data_out), 64'(31));
    step(1'b1, 1'b1, 1'b0, '0);
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    clear_counts();
    step(1'b0, 1'b1, 1'b1, ramp_frame());
    idle(75);
    check("post_rst_count", 64'(n_seen), 64'(72));

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 9) < 3), rand_frame());
    idle(160);

    // LENGTH=1 build: a frame every cycle, each reappears one cycle later as start+last
    clken = 1'b1;
    prev1 = '0;
    for (int i = 0; i < 40; i++) begin
      cur1                = BW'($urandom);
      bus1.frame_in_valid = 1'b1;
      bus1.frame_in       = cur1;
      #1;
      check("l1_overflow", 64'(bus1.overflow), 64'(0));
      check("l1_ready", 64'(bus1.frame_in_ready), 64'(1));
      @(posedge clk);
      #1;
      check("l1_valid", 64'(bus1.data_out_valid), 64'(i > 0));
      if (i > 0) begin
        check("l1_data", 64'(bus1.data_out), 64'(prev1));
        check("l1_start", 64'(bus1.frame_start), 64'(1));
        check("l1_last", 64'(bus1.frame_last), 64'(1));
      end
      prev1 = cur1;
    end
    bus1.frame_in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
